// File: rtl/fu_seq_pkg.sv
// fu_seq_pkg: shared op/FS encodings and FSM state type for fu_sequencer.
// FU_SEQ_MUL_EN adds the multiply iteration states.
package fu_seq_pkg;
  localparam logic [1:0] OP_FU  = 2'd0;
  localparam logic [1:0] OP_LDI = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_RSV = 2'd3;
  localparam logic [3:0] FS_IDLE = 4'b0000;
  localparam logic [3:0] FS_ADD  = 4'b0010;
  localparam logic [3:0] FS_SHR  = 4'b1101;
  localparam logic [3:0] FS_SHL  = 4'b1110;
  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
`ifdef FU_SEQ_MUL_EN
    S_MUL_ADD,
    S_MUL_SHL,
    S_MUL_SHR,
`endif
    S_DONE
  } state_t;
endpackage

// File: rtl/fu_seq_regfile.sv
// fu_seq_regfile: NREG x DW register file, one sync write port, operand and readback comb reads.
module fu_seq_regfile #(
  parameter int DW = 8,
  parameter int NREG = 4,
  parameter int AW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b,
  input  logic [AW-1:0] raddr_c,
  output logic [DW-1:0] rdata_c
);
  logic [DW-1:0] mem [NREG];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < NREG; i++) mem[i] <= '0;
    else if (we) mem[waddr] <= wdata;
  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];
  assign rdata_c = mem[raddr_c];
endmodule

// File: rtl/fu_sequencer.sv
// fu_sequencer: command-driven sequencer for an external 8-bit ALU/shifter with a 4x8 register file.
// FU_SEQ_MUL_EN enables the shift-add 8x8 multiply; otherwise MUL is rejected like the reserved op.
module fu_sequencer import fu_seq_pkg::*; #(
  parameter int DW = 8,
  parameter int NREG = 4,
  localparam int AW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [3:0]    cmd_fs,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_ra,
  input  logic [AW-1:0] cmd_rb,
  input  logic [DW-1:0] cmd_imm,
  output logic          done,
  output logic          err,
  output logic          busy,
  output logic          flag_v,
  output logic          flag_c,
  output logic          flag_n,
  output logic          flag_z,
  output logic [3:0]    fu_fs,
  output logic [DW-1:0] fu_a,
  output logic [DW-1:0] fu_b,
  input  logic [DW-1:0] fu_f,
  input  logic          fu_v,
  input  logic          fu_c,
  input  logic          fu_n,
  input  logic          fu_z,
  input  logic [AW-1:0] rdbk_addr,
  output logic [DW-1:0] rdbk_data
);
`ifdef FU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  state_t state, nxt;
  logic [1:0] op;
  logic [3:0] fs;
  logic [AW-1:0] rd;
  logic [DW-1:0] opa, opb, imm, rd_a, rd_b, reg_wd;
  logic [3:0] flags, flag_d;
  logic accept, reg_we, flag_we;
  assign accept = cmd_valid && cmd_ready;
  fu_seq_regfile #(.DW(DW), .NREG(NREG)) u_rf (
    .clk(clk), .rst_n(rst_n), .we(reg_we), .waddr(rd), .wdata(reg_wd),
    .raddr_a(cmd_ra), .rdata_a(rd_a), .raddr_b(cmd_rb), .rdata_b(rd_b),
    .raddr_c(rdbk_addr), .rdata_c(rdbk_data)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op <= OP_FU; fs <= FS_IDLE; rd <= '0; opa <= '0; opb <= '0; imm <= '0;
    end else if (accept) begin
      op <= cmd_op; fs <= cmd_fs; rd <= cmd_rd; opa <= rd_a; opb <= rd_b; imm <= cmd_imm;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) flags <= '0;
    else if (flag_we) flags <= flag_d;
  assign {flag_v, flag_c, flag_n, flag_z} = flags;
`ifdef FU_SEQ_MUL_EN
  logic [DW-1:0] acc, mcand, mplr;
  logic [2:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0; mcand <= '0; mplr <= '0; cnt <= '0;
    end else if (accept) begin
      acc <= '0; mcand <= rd_a; mplr <= rd_b; cnt <= '0;
    end else if (state == S_MUL_ADD && mplr[0]) acc <= fu_f;
    else if (state == S_MUL_SHL) mcand <= fu_f;
    else if (state == S_MUL_SHR) begin
      mplr <= fu_f; cnt <= cnt + 3'd1;
    end
`endif
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (cmd_valid) nxt = (cmd_op == OP_FU || cmd_op == OP_LDI) ? S_EXEC :
`ifdef FU_SEQ_MUL_EN
        (cmd_op == OP_MUL) ? S_MUL_ADD :
`endif
        S_DONE;
      S_EXEC: nxt = S_DONE;
`ifdef FU_SEQ_MUL_EN
      S_MUL_ADD: nxt = S_MUL_SHL;
      S_MUL_SHL: nxt = S_MUL_SHR;
      S_MUL_SHR: nxt = (cnt == 3'd7) ? S_DONE : S_MUL_ADD;
`endif
      default: nxt = S_IDLE;
    endcase
  end
  always_comb begin
    fu_fs = FS_IDLE;
    fu_a = '0;
    fu_b = '0;
    reg_we = 1'b0;
    reg_wd = fu_f;
    flag_we = 1'b0;
    flag_d = {fu_v, fu_c, fu_n, fu_z};
    case (state)
      S_EXEC: begin
        fu_fs = (op == OP_FU) ? fs : FS_IDLE;
        fu_a = (op == OP_FU) ? opa : '0;
        fu_b = (op == OP_FU) ? opb : '0;
        reg_we = 1'b1;
        reg_wd = (op == OP_LDI) ? imm : fu_f;
        flag_we = (op == OP_FU);
      end
`ifdef FU_SEQ_MUL_EN
      S_MUL_ADD: begin
        fu_fs = FS_ADD; fu_a = acc; fu_b = mcand;
      end
      S_MUL_SHL: begin
        fu_fs = FS_SHL; fu_b = mcand;
      end
      S_MUL_SHR: begin
        fu_fs = FS_SHR; fu_b = mplr;
        reg_we = (cnt == 3'd7);
        reg_wd = acc;
        flag_we = (cnt == 3'd7);
        flag_d = {2'b00, acc[DW-1], acc == '0};
      end
`endif
      default: ;
    endcase
  end
  assign cmd_ready = (state == S_IDLE);
  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);
  assign err = done && !(op == OP_FU || op == OP_LDI || (MUL_EN && op == OP_MUL));
endmodule

// File: tb/tb_fu_sequencer.sv
// tb_fu_sequencer: directed checks of fu_sequencer against a behavioural FU model.
// Expectations follow FU_SEQ_MUL_EN when the bench is built with it.
module tb_fu_sequencer;
  import fu_seq_pkg::*;
`ifdef FU_SEQ_MUL_EN
  localparam int MUL_LAT = 25;
  localparam bit MUL_ERR = 1'b0;
`else
  localparam int MUL_LAT = 1;
  localparam bit MUL_ERR = 1'b1;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, done, err, busy;
  logic flag_v, flag_c, flag_n, flag_z, fu_v, fu_c, fu_n, fu_z;
  logic [1:0] cmd_op = '0, cmd_rd = '0, cmd_ra = '0, cmd_rb = '0, rdbk_addr = '0;
  logic [3:0] cmd_fs = '0, fu_fs;
  logic [7:0] cmd_imm = '0, fu_a, fu_b, fu_f, rdbk_data;
  int n_chk = 0, n_bad = 0, n_done = 0, lat;
  logic e;

  fu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_fs(cmd_fs), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .cmd_imm(cmd_imm), .done(done), .err(err), .busy(busy),
    .flag_v(flag_v), .flag_c(flag_c), .flag_n(flag_n), .flag_z(flag_z),
    .fu_fs(fu_fs), .fu_a(fu_a), .fu_b(fu_b), .fu_f(fu_f),
    .fu_v(fu_v), .fu_c(fu_c), .fu_n(fu_n), .fu_z(fu_z),
    .rdbk_addr(rdbk_addr), .rdbk_data(rdbk_data)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (done) n_done++;

  always_comb begin
    fu_f = 8'h00;
    fu_c = 1'b0;
    fu_v = 1'b0;
    case (fu_fs)
      FS_ADD: begin
        {fu_c, fu_f} = {1'b0, fu_a} + {1'b0, fu_b};
        fu_v = (fu_a[7] == fu_b[7]) && (fu_f[7] != fu_a[7]);
      end
      FS_SHR: begin
        fu_f = {1'b0, fu_b[7:1]};
        fu_c = fu_b[0];
      end
      FS_SHL: begin
        fu_f = {fu_b[6:0], 1'b0};
        fu_c = fu_b[7];
      end
      default: ;
    endcase
    fu_n = fu_f[7];
    fu_z = (fu_f == 8'h00);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic rb(input string tag, input logic [1:0] a, input logic [7:0] exp);
    rdbk_addr = a;
    #1 chk(tag, rdbk_data, exp);
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] fs, input logic [1:0] rd,
                       input logic [1:0] ra, input logic [1:0] rbb, input logic [7:0] imm);
    int w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 40) begin @(negedge clk); w++; end
    if (w >= 40) chk("ready_timeout", 0, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_fs = fs; cmd_rd = rd; cmd_ra = ra; cmd_rb = rbb; cmd_imm = imm;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [3:0] fs, input logic [1:0] rd,
                        input logic [1:0] ra, input logic [1:0] rbb, input logic [7:0] imm,
                        output int l, output logic er);
    issue(op, fs, rd, ra, rbb, imm);
    l = 1;
    while (!done && l < 40) begin @(negedge clk); l++; end
    er = err;
  endtask

  initial begin
    int d0;
    repeat (2) @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done_err", {done, err}, 0);
    chk("rst_flags", {flag_v, flag_c, flag_n, flag_z}, 0);
    chk("rst_fu", {fu_fs, fu_a, fu_b}, 0);
    rst_n = 1'b1;
    rb("rst_r1", 1, 8'h00);

    do_cmd(OP_LDI, 4'h0, 2'd1, 2'd0, 2'd0, 8'h7F, lat, e);
    chk("ldi1_lat", lat, 2);
    chk("ldi1_err", e, 0);
    do_cmd(OP_LDI, 4'h0, 2'd2, 2'd0, 2'd0, 8'h01, lat, e);
    chk("ldi2_lat", lat, 2);
    rb("ldi_r1", 1, 8'h7F);
    rb("ldi_r2", 2, 8'h01);

    do_cmd(OP_FU, FS_ADD, 2'd3, 2'd1, 2'd2, 8'h00, lat, e);
    chk("add_lat", lat, 2);
    chk("add_err", e, 0);
    rb("add_r3", 3, 8'h80);
    chk("add_flags", {flag_v, flag_c, flag_n, flag_z}, 4'b1010);

    do_cmd(OP_RSV, 4'h0, 2'd3, 2'd1, 2'd2, 8'h55, lat, e);
    chk("rsv_lat", lat, 1);
    chk("rsv_err", e, 1);
    rb("rsv_r3", 3, 8'h80);
    chk("rsv_flags", {flag_v, flag_c, flag_n, flag_z}, 4'b1010);

    do_cmd(OP_LDI, 4'h0, 2'd1, 2'd0, 2'd0, 8'd13, lat, e);
    do_cmd(OP_LDI, 4'h0, 2'd2, 2'd0, 2'd0, 8'd11, lat, e);
    do_cmd(OP_MUL, 4'h0, 2'd1, 2'd1, 2'd2, 8'h00, lat, e);
    chk("mul_lat", lat, MUL_LAT);
    chk("mul_err", e, MUL_ERR);
`ifdef FU_SEQ_MUL_EN
    rb("mul_r1", 1, 8'h8F);
    chk("mul_flags", {flag_v, flag_c, flag_n, flag_z}, 4'b0010);
`else
    rb("mul_r1", 1, 8'd13);
    chk("mul_flags", {flag_v, flag_c, flag_n, flag_z}, 4'b1010);
`endif

    do_cmd(OP_LDI, 4'h0, 2'd1, 2'd0, 2'd0, 8'h10, lat, e);
    do_cmd(OP_LDI, 4'h0, 2'd2, 2'd0, 2'd0, 8'h10, lat, e);
    do_cmd(OP_MUL, 4'h0, 2'd3, 2'd1, 2'd2, 8'h00, lat, e);
    chk("wrap_err", e, MUL_ERR);
`ifdef FU_SEQ_MUL_EN
    rb("wrap_r3", 3, 8'h00);
    chk("wrap_flags", {flag_v, flag_c, flag_n, flag_z}, 4'b0001);
`else
    rb("wrap_r3", 3, 8'h80);
`endif

    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_MUL; cmd_rd = 2'd3; cmd_ra = 2'd1; cmd_rb = 2'd2;
    @(negedge clk);
    cmd_op = OP_LDI; cmd_rd = 2'd0; cmd_imm = 8'hAA;
    lat = 1;
    while (!done && lat < 40) begin @(negedge clk); lat++; end
    chk("busy_lat", lat, MUL_LAT);
    rb("busy_r0", 0, 8'h00);
    @(negedge clk);
    chk("busy_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("busy_ldi_done", {done, err}, 2'b10);
    rb("busy_ldi_r0", 0, 8'hAA);

    issue(OP_MUL, 4'h0, 2'd3, 2'd1, 2'd0, 8'h00);
    repeat (9) @(negedge clk);
    d0 = n_done;
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_ready", cmd_ready, 1);
    chk("mrst_flags", {flag_v, flag_c, flag_n, flag_z}, 0);
    rb("mrst_r0", 0, 8'h00);
    rb("mrst_r1", 1, 8'h00);
    rb("mrst_r3", 3, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("mrst_no_done", n_done, d0);
    chk("mrst_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
